// File: rtl/dp_ram_reader_pkg.sv
// Shared types for the dual-port RAM stream reader: FSM states, skid FIFO depth and entry layout.
// The FIFO depth of 2 matches the RAM's 1-cycle read latency, so the reader sustains one word per cycle.
package dp_ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  localparam int FIFO_DEPTH   = 2;
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_DATA_W = 32;

  // Entry layout at the default data width; the reader builds the same shape at its own DATA_WIDTH.
  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic                    last;
  } fifo_entry_t;

endpackage

// File: rtl/dp_ram_reader_skid_fifo.sv
// 2-entry skid FIFO with push/pop/count. Head is visible the cycle after push (0 cycles of fall-through).
// Simultaneous push and pop keep the count unchanged; the producer must never push into a full FIFO.
module dp_ram_reader_skid_fifo
  import dp_ram_reader_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [W-1:0]          push_dat_i,
  input  logic                  pop_i,
  output logic [W-1:0]          head_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (!(push_i && !pop_i && count_q == FIFO_CNT_W'(FIFO_DEPTH)));
      assert (!(pop_i && count_q == '0));
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dp_ram_stream_reader.sv
// Sequential RAM read initiator -> valid/ready stream; first beat 2 cycles after the start edge, 1 beat/cycle.
// Backpressure throttles RAM issue via a 2-entry skid FIFO. DP_RAM_READER_STALL_CNT_EN adds stall_cnt_o.
module dp_ram_stream_reader
  import dp_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   start_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
`ifdef DP_RAM_READER_STALL_CNT_EN
  output logic [31:0]             stall_cnt_o,
`endif
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    m_valid_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic                    m_last_o,
  input  logic                    m_ready_i
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q;
  logic                  done_q, done_d;

  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [FIFO_CNT_W:0]   occ;
  logic                  pop;
  logic                  ram_en;
  entry_t                push_ent;
  entry_t                head_ent;

  assign pop = m_valid_o & m_ready_i;

  // Occupancy after this cycle's pop; issuing only below depth keeps FIFO + in-flight read within 2.
  assign occ    = {1'b0, fifo_cnt} + {{FIFO_CNT_W{1'b0}}, inflight_q} - {{FIFO_CNT_W{1'b0}}, pop};
  assign ram_en = (state_q == ISSUE) && (occ < (FIFO_CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d     = ISSUE;
            addr_d      = start_addr_i;
            issue_cnt_d = len_i;
            beat_cnt_d  = len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ram_en) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          if (issue_cnt_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (inflight_q) beat_cnt_d = beat_cnt_q - LEN_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= ram_en;
      done_q      <= done_d;
    end
  end

  // beat_cnt_q counts words still to be captured, so the final capture sees exactly one left.
  assign push_ent.data = ram_rdata_i;
  assign push_ent.last = (beat_cnt_q == LEN_ONE);

  dp_ram_reader_skid_fifo #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (inflight_q),
    .push_dat_i(push_ent),
    .pop_i     (pop),
    .head_o    (head_ent),
    .count_o   (fifo_cnt)
  );

`ifdef DP_RAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == IDLE && start_i)) begin
      stall_cnt_q <= '0;
    end else if (m_valid_o && !m_ready_i && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign ram_en_o    = ram_en;
  assign ram_addr_o  = addr_q;
  assign ram_we_o    = 1'b0;
  assign ram_be_o    = '1;
  assign ram_wdata_o = '0;
  assign m_valid_o   = (fifo_cnt != '0);
  assign m_data_o    = head_ent.data;
  assign m_last_o    = head_ent.last;

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Bench for dp_ram_stream_reader: behavioural 1-cycle RAM, beat/address scoreboards, vector table
// plus hand-written sequences for len=0, ignored start, mid-stream reset and the optional stall counter.
module tb_dp_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  start_addr_i;
  logic [10:0] len_i;
  logic        busy_o, done_o;
  logic        ram_en_o, ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        m_valid_o, m_last_o, m_ready_i;
  logic [31:0] m_data_o;
`ifdef DP_RAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  dp_ram_stream_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
`ifdef DP_RAM_READER_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i)
  );

  logic [31:0] mem [1024];
  always @(posedge clk) if (ram_en_o) ram_rdata_i <= mem[ram_addr_o];

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [9:0]  addr;
    logic [10:0] len;
    int          mode;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  beat_t      exp_q[$];
  logic [9:0] addr_exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  logic ready_man = 1'b0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int          start_cyc, first_cyc, done_cyc, done_cnt, beats_got;
  int          issued_n, accepted_n;
  logic        busy_seen, valid_seen;
  logic [31:0] first_data, last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // 0: ready high, 1: fixed toggle pattern, 2: random, 3: ready_man
  initial begin
    int k = 0;
    m_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       begin m_ready_i = pat[k % 6]; k++; end
        2:       m_ready_i = 1'($urandom_range(0, 1));
        default: m_ready_i = ready_man;
      endcase
    end
  end

  always @(negedge clk) begin
    int   occ;
    logic pop;
    beat_t e;
    if (!rst_i) begin
      pop = m_valid_o && m_ready_i;
      if (busy_o) busy_seen = 1'b1;
      if (m_valid_o) begin
        valid_seen = 1'b1;
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ram_en_o) begin
        occ = issued_n - accepted_n + 1 - int'(pop);
        total++;
        if (occ > 2) begin
          bad++;
          $display("FAIL occupancy: got %0d want <=2", occ);
        end
        if (addr_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_issue: got addr %0d want no ram_en_o", ram_addr_o);
        end else begin
          chk("ram_addr", 64'(ram_addr_o), 64'(addr_exp_q.pop_front()));
        end
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got 0x%0h want no beat", m_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_data_o), 64'(e.data));
          chk("beat_last", 64'(m_last_o), 64'(e.last));
        end
        if (beats_got == 0) first_data = m_data_o;
        last_data = m_data_o;
        beats_got++;
      end
      issued_n   += int'(ram_en_o);
      accepted_n += int'(pop);
    end
  end

  task automatic start_cmd(input logic [9:0] a, input logic [10:0] l);
    logic [9:0] ai;
    for (int i = 0; i < int'(l); i++) begin
      ai = a + 10'(i);
      exp_q.push_back({mem[ai], (i == int'(l) - 1)});
      addr_exp_q.push_back(ai);
    end
    first_cyc = -1; done_cyc = -1; done_cnt = 0; beats_got = 0;
    busy_seen = 1'b0; valid_seen = 1'b0;
    start_addr_i = a; len_i = l; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done_o within %0d cycles want pulse", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     64'(busy_o),     64'(0));
    chk({tag, "_done"},     64'(done_o),     64'(0));
    chk({tag, "_ram_en"},   64'(ram_en_o),   64'(0));
    chk({tag, "_ram_addr"}, 64'(ram_addr_o), 64'(0));
    chk({tag, "_valid"},    64'(m_valid_o),  64'(0));
    chk({tag, "_data"},     64'(m_data_o),   64'(0));
    chk({tag, "_last"},     64'(m_last_o),   64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   n;
    int   issued_before;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
    for (int j = 0; j < 4; j++) mem[16 + j] = 32'h0000_00A0 + 32'(j);

    vecs[0] = '{10'd16,   11'd4,    0, 32'h0000_00A0, 32'h0000_00A3};
    vecs[1] = '{10'd16,   11'd4,    1, 32'h0000_00A0, 32'h0000_00A3};
    vecs[2] = '{10'd1022, 11'd4,    0, 32'hC000_03FE, 32'hC000_0001};
    vecs[3] = '{10'd5,    11'd1,    1, 32'hC000_0005, 32'hC000_0005};
    vecs[4] = '{10'd1000, 11'd40,   2, 32'hC000_03E8, 32'hC000_000F};
    vecs[5] = '{10'd0,    11'd1024, 0, 32'hC000_0000, 32'hC000_03FF};

    rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; len_i = '0;
    issued_n = 0; accepted_n = 0; done_cnt = 0; beats_got = 0;
    first_cyc = -1; done_cyc = -1; busy_seen = 1'b0; valid_seen = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("const_we",    64'(ram_we_o),    64'(0));
    chk("const_be",    64'(ram_be_o),    64'(4'hF));
    chk("const_wdata", 64'(ram_wdata_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      mode = vecs[v].mode;
      start_cmd(vecs[v].addr, vecs[v].len);
      @(negedge clk);
      chk($sformatf("v%0d_busy", v), 64'(busy_o), 64'(1));
      wait_done(int'(vecs[v].len) * 8 + 50);
      chk($sformatf("v%0d_beats", v),  64'(beats_got),  64'(vecs[v].len));
      chk($sformatf("v%0d_first", v),  64'(first_data), 64'(vecs[v].first));
      chk($sformatf("v%0d_lastd", v),  64'(last_data),  64'(vecs[v].last));
      chk($sformatf("v%0d_done_n", v), 64'(done_cnt),   64'(1));
      chk($sformatf("v%0d_sb", v),     64'(exp_q.size() + addr_exp_q.size()), 64'(0));
      chk($sformatf("v%0d_idle", v),   64'(busy_o),     64'(0));
      if (vecs[v].mode == 0) begin
        chk($sformatf("v%0d_first_lat", v), 64'(first_cyc - start_cyc), 64'(2));
        chk($sformatf("v%0d_done_lat", v),  64'(done_cyc - start_cyc),  64'(int'(vecs[v].len) + 2));
      end
    end

    // len=0: immediate done, no RAM traffic, never busy
    mode = 0;
    issued_before = issued_n;
    start_cmd(10'd200, 11'd0);
    repeat (4) @(negedge clk);
    chk("len0_done_n",   64'(done_cnt),             64'(1));
    chk("len0_done_lat", 64'(done_cyc - start_cyc), 64'(0));
    chk("len0_busy",     64'(busy_seen),            64'(0));
    chk("len0_valid",    64'(valid_seen),           64'(0));
    chk("len0_issues",   64'(issued_n - issued_before), 64'(0));

    // start while busy is ignored
    mode = 1;
    start_cmd(10'd16, 11'd4);
    repeat (2) @(negedge clk);
    start_addr_i = 10'd500; len_i = 11'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(100);
    chk("ign_beats",  64'(beats_got),  64'(4));
    chk("ign_lastd",  64'(last_data),  64'(32'hA3));
    chk("ign_done_n", 64'(done_cnt),   64'(1));
    chk("ign_sb",     64'(exp_q.size() + addr_exp_q.size()), 64'(0));

    // reset mid-stream with data in flight and FIFO full
    mode = 3; ready_man = 1'b1;
    start_cmd(10'd100, 11'd8);
    n = 0;
    while (beats_got < 2 && n < 50) begin @(negedge clk); n++; end
    ready_man = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    exp_q.delete(); addr_exp_q.delete();
    issued_n = 0; accepted_n = 0; done_cnt = 0;
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done",  64'(done_cnt),  64'(0));
    chk("midrst_no_valid", 64'(m_valid_o), 64'(0));
    mode = 0;
    start_cmd(10'd0, 11'd2);
    wait_done(50);
    chk("post_beats",  64'(beats_got),  64'(2));
    chk("post_first",  64'(first_data), 64'(32'hC000_0000));
    chk("post_lastd",  64'(last_data),  64'(32'hC000_0001));
    chk("post_done_n", 64'(done_cnt),   64'(1));

`ifdef DP_RAM_READER_STALL_CNT_EN
    mode = 3; ready_man = 1'b0;
    start_cmd(10'd40, 11'd3);
    n = 0;
    while (!m_valid_o && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    ready_man = 1'b1;
    wait_done(50);
    chk("stall_cnt", 64'(stall_cnt_o), 64'(5));
    chk("stall_beats", 64'(beats_got), 64'(3));
    mode = 0;
    start_cmd(10'd40, 11'd1);
    @(negedge clk);
    chk("stall_clear", 64'(stall_cnt_o), 64'(0));
    wait_done(50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
